// File: rtl/busca_instrucao_if.sv
`default_nettype none
// ============================================================================
// Module      : busca_instrucao_if
// Description : Instruction-memory and control-unit handshake bundle for the
//               NRISC instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface busca_instrucao_if #(
  parameter int unsigned PC_W = 8
) ();
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [7:0]      imem_data;
  logic [7:0]      instr_out;
  logic [2:0]      opcode;
  logic [1:0]      funct;
  logic [PC_W-1:0] pc_out;
  logic            instr_valid;
  logic            instr_ready;
  logic            branch_taken;
  logic [PC_W-1:0] branch_target;
  logic            resume;
  logic            halt;

  modport master (
    output imem_req, imem_addr, instr_out, opcode, funct, pc_out, instr_valid, halt,
    input  imem_valid, imem_data, instr_ready, branch_taken, branch_target, resume
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, opcode, funct, pc_out, instr_valid, halt,
    output imem_valid, imem_data, instr_ready, branch_taken, branch_target, resume
  );
endinterface
`default_nettype wire

// File: rtl/busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module      : busca_instrucao
// Description : NRISC instruction-fetch stage: PC, variable-latency fetch,
//               instruction register, beq redirect and halt/resume.
// Revision    : 1.0 - initial release
// ============================================================================
module busca_instrucao #(
  parameter int unsigned       PC_W     = 8,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  busca_instrucao_if.master bus
);

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;
  logic [7:0]      instr_q, instr_d;
  logic            flush_q, flush_d;

  logic [PC_W-1:0] w_pc_inc;
  logic            w_is_halt;

  assign w_pc_inc  = pc_q + c_pc_one;
  assign w_is_halt = (instr_q[7:5] == 3'b110) && (instr_q[1:0] == 2'b11);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_START;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      pc_out_q <= RESET_PC;
      instr_q  <= 8'h00;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      flush_q  <= flush_d;
    end
  end

  // addr_q only moves when a new transaction begins, so imem_addr stays
  // stable for the whole request even if a branch updates pc mid-flight.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    flush_d  = flush_q;
    case (state_q)
      ST_START: begin
        state_d = ST_FETCH;
        addr_d  = pc_q;
      end
      ST_FETCH: begin
        if (bus.branch_taken) begin
          pc_d = bus.branch_target;
          if (bus.imem_valid) begin
            flush_d = 1'b0;
            addr_d  = bus.branch_target;
          end else begin
            flush_d = 1'b1;
          end
        end else if (bus.imem_valid) begin
          if (flush_q) begin
            flush_d = 1'b0;
            addr_d  = pc_q;
          end else begin
            instr_d  = bus.imem_data;
            pc_out_d = pc_q;
            state_d  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.branch_taken) begin
          pc_d    = bus.branch_target;
          addr_d  = bus.branch_target;
          state_d = ST_FETCH;
        end else if (bus.instr_ready) begin
          if (w_is_halt) begin
            state_d = ST_HALTED;
          end else begin
            pc_d    = w_pc_inc;
            addr_d  = w_pc_inc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALTED: begin
        if (bus.resume) begin
          pc_d    = w_pc_inc;
          addr_d  = w_pc_inc;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  assign bus.imem_req    = (state_q == ST_FETCH);
  assign bus.imem_addr   = addr_q;
  assign bus.instr_out   = instr_q;
  assign bus.opcode      = instr_q[7:5];
  assign bus.funct       = instr_q[1:0];
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = (state_q == ST_HOLD);
  assign bus.halt        = (state_q == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_busca_instrucao.sv
`default_nettype none
// ============================================================================
// Module      : tb_busca_instrucao
// Description : Directed and randomized bench for busca_instrucao with a
//               transaction-level reference model of the fetch stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_busca_instrucao;

  localparam int unsigned PC_W     = 8;
  localparam logic [7:0]  RESET_PC = 8'h00;

  logic clock = 1'b0;
  logic reset = 1'b1;

  busca_instrucao_if #(.PC_W(PC_W)) bif ();

  busca_instrucao #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.master)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: the program counter the stream should continue from,
  // plus the memory image the responder serves.
  logic [7:0]  mem [256];
  logic [7:0]  exp_pc;
  logic        halted_m;
  logic        stale;
  logic        expect_present;
  logic        expect_refetch;
  logic [15:0] log_q [$];

  // Memory responder bookkeeping
  logic        busy;
  int          cnt;
  logic [7:0]  addr_l;

  // Stimulus knobs
  int          lat        = 1;
  bit          lat_rand   = 1'b0;
  int          ready_pct  = 100;
  int          br_pct     = 0;
  int          res_pct    = 0;
  int          hold_wait  = 0;
  int          br_hold_at = -1;
  logic [7:0]  br_hold_tgt;
  int          br_fetch_at = -1;
  logic [7:0]  br_fetch_tgt;
  int          idle = 0;

  function automatic bit is_halt(input logic [7:0] w);
    return (w[7:5] == 3'b110) && (w[1:0] == 2'b11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk = n_chk + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_init();
    exp_pc         = RESET_PC;
    halted_m       = 1'b0;
    stale          = 1'b0;
    expect_present = 1'b0;
    expect_refetch = 1'b0;
    busy           = 1'b0;
    cnt            = 0;
    hold_wait      = 0;
    idle           = 0;
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    bif.imem_valid    = 1'b1;
    bif.imem_data     = 8'($urandom);
    bif.instr_ready   = 1'b1;
    bif.branch_taken  = 1'b0;
    bif.branch_target = 8'($urandom);
    bif.resume        = 1'b1;
    @(posedge clock); #1;
    chk("rst_imem_req", bif.imem_req, 0);
    chk("rst_instr_valid", bif.instr_valid, 0);
    chk("rst_halt", bif.halt, 0);
    chk("rst_instr_out", bif.instr_out, 0);
    chk("rst_imem_addr", bif.imem_addr, RESET_PC);
    @(posedge clock); #1;
    reset = 1'b0;
    model_init();
  endtask

  // One clock: check what the model predicted, choose inputs, advance model.
  task automatic tick();
    logic       br;
    logic [7:0] tgt;
    logic       rdy;
    logic       vld;
    logic       res;
    logic [7:0] dat;

    if (expect_present) begin
      chk("present_valid", bif.instr_valid, 1);
      chk("present_pc", bif.pc_out, exp_pc);
      chk("present_instr", bif.instr_out, mem[exp_pc]);
      chk("present_opcode", bif.opcode, mem[exp_pc] >> 5);
      chk("present_funct", bif.funct, mem[exp_pc] & 8'h03);
      chk("hold_no_req", bif.imem_req, 0);
    end
    expect_present = 1'b0;
    if (expect_refetch) begin
      chk("refetch_req", bif.imem_req, 1);
      chk("refetch_no_valid", bif.instr_valid, 0);
    end
    expect_refetch = 1'b0;
    if (halted_m) begin
      chk("halted_halt", bif.halt, 1);
      chk("halted_no_req", bif.imem_req, 0);
      chk("halted_no_valid", bif.instr_valid, 0);
    end else begin
      chk("running_halt", bif.halt, 0);
    end
    chk("req_valid_exclusive", bif.imem_req & bif.instr_valid, 0);

    br  = ($urandom_range(0, 99) < br_pct);
    tgt = 8'($urandom);
    rdy = ($urandom_range(0, 99) < ready_pct);
    res = ($urandom_range(0, 99) < res_pct);
    vld = 1'($urandom_range(0, 1));
    dat = 8'($urandom);

    if (bif.imem_req) begin
      if (!busy) begin
        busy   = 1'b1;
        cnt    = lat_rand ? $urandom_range(1, 5) : lat;
        addr_l = bif.imem_addr;
        chk("req_addr", bif.imem_addr, exp_pc);
        if (br_fetch_at == int'(exp_pc)) begin
          br          = 1'b1;
          tgt         = br_fetch_tgt;
          br_fetch_at = -1;
        end
      end else begin
        chk("req_addr_stable", bif.imem_addr, addr_l);
      end
      cnt = cnt - 1;
      vld = (cnt == 0);
      if (vld) dat = mem[addr_l];
      if (br) begin
        stale  = 1'b1;
        exp_pc = tgt;
      end
      if (vld) begin
        busy = 1'b0;
        if (stale) expect_refetch = 1'b1;
        else       expect_present = 1'b1;
        stale = 1'b0;
      end
    end else begin
      busy  = 1'b0;
      stale = 1'b0;
      if (bif.instr_valid) begin
        if (br_hold_at == int'(exp_pc)) begin
          br         = 1'b1;
          tgt        = br_hold_tgt;
          br_hold_at = -1;
        end
        if (hold_wait > 0) begin
          rdy       = 1'b0;
          hold_wait = hold_wait - 1;
        end
        if (br || rdy) log_q.push_back({bif.pc_out, bif.instr_out});
        if (br) begin
          exp_pc         = tgt;
          expect_refetch = 1'b1;
        end else if (rdy) begin
          if (is_halt(mem[exp_pc])) begin
            halted_m = 1'b1;
          end else begin
            exp_pc         = exp_pc + 8'd1;
            expect_refetch = 1'b1;
          end
        end else begin
          expect_present = 1'b1;
        end
      end else if (bif.halt && res) begin
        halted_m       = 1'b0;
        exp_pc         = exp_pc + 8'd1;
        expect_refetch = 1'b1;
      end
    end

    bif.imem_valid    = vld;
    bif.imem_data     = dat;
    bif.instr_ready   = rdy;
    bif.branch_taken  = br;
    bif.branch_target = tgt;
    bif.resume        = res;

    if (bif.instr_valid || bif.halt) idle = 0;
    else idle = idle + 1;
    if (idle > 60) begin
      chk("liveness_idle_cycles", idle, 0);
      idle = 0;
    end

    @(posedge clock); #1;
  endtask

  task automatic run_until_log(input int n);
    int k;
    k = 0;
    while (log_q.size() < n && k < 300) begin
      tick();
      k++;
    end
    if (log_q.size() < n) chk("progress_timeout", log_q.size(), n);
  endtask

  initial begin
    bif.imem_valid    = 1'b0;
    bif.imem_data     = 8'h00;
    bif.instr_ready   = 1'b0;
    bif.branch_taken  = 1'b0;
    bif.branch_target = 8'h00;
    bif.resume        = 1'b0;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if (is_halt(mem[i])) mem[i] = mem[i] ^ 8'h01;
    end
    mem[0]     = 8'h01;
    mem[1]     = 8'h22;
    mem[2]     = 8'h43;
    mem[3]     = 8'hE5;
    mem[4]     = 8'h77;
    mem[5]     = 8'hC3;
    mem[8'h10] = 8'h5A;

    // Latency 1, always ready
    do_reset();
    lat = 1; ready_pct = 100; br_pct = 0; res_pct = 0;
    run_until_log(2);

    // Latency 4 and ready held low for 5 cycles on pc 2
    lat = 4; hold_wait = 5;
    run_until_log(3);
    chk("t1_entry0", log_q[0], 16'h0001);
    chk("t1_entry1", log_q[1], 16'h0122);
    chk("t1_entry2", log_q[2], 16'h0243);

    // beq held at pc 3 -> 0x10, then a branch during that fetch -> 0x20
    lat = 3;
    br_hold_at = 3;     br_hold_tgt  = 8'h10;
    br_fetch_at = 8'h10; br_fetch_tgt = 8'h20;
    run_until_log(4);
    chk("t3_beq_entry", log_q[3], 16'h03E5);

    // From 0x20 branch to 5 where the halt word lives
    lat = 2;
    br_hold_at = 8'h20; br_hold_tgt = 8'h05;
    run_until_log(5);
    chk("t4_first_after_flush", log_q[4], {8'h20, mem[8'h20]});
    run_until_log(6);
    chk("t5_halt_entry", log_q[5], 16'h05C3);
    repeat (6) tick();
    chk("t5_still_halted", bif.halt, 1);

    // Resume -> fetch from 6; then branch to 0xFF and wrap to 0x00
    res_pct = 100;
    br_hold_at = 6; br_hold_tgt = 8'hFF;
    run_until_log(7);
    chk("t5_resume_pc", log_q[6], {8'h06, mem[6]});
    res_pct = 0;
    run_until_log(9);
    chk("t6_pc_ff", log_q[7], {8'hFF, mem[8'hFF]});
    chk("t6_wrap_pc", log_q[8], {8'h00, mem[0]});
    for (int i = 0; i < 9; i++) chk("t3_pc4_never_presented", log_q[i][15:8] == 8'h04, 0);

    // Reset while a fetch is outstanding
    lat = 4;
    for (int k = 0; k < 20 && !bif.imem_req; k++) tick();
    tick();
    do_reset();
    run_until_log(10);
    chk("t6_refetch_after_reset", log_q[9], {RESET_PC, mem[RESET_PC]});

    // Randomized traffic, halt words allowed
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    lat_rand = 1'b1; ready_pct = 60; br_pct = 8; res_pct = 30;
    do_reset();
    repeat (1500) tick();
    do_reset();
    repeat (1500) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
